// File: rtl/add_shift_mul_seq_pkg.sv
// Shared types and constants for the shift-and-add multiplier sequencer.
package add_shift_mul_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 32;

  // Iteration counter must be able to hold the value WIDTH itself.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/add_shift_mul_seq_if.sv
// Operand/result handshake bundle for add_shift_mul_seq.
// master drives operands and accepts the product; slave is the multiplier.
interface add_shift_mul_seq_if
  import add_shift_mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );

endinterface

// File: rtl/add_shift_mul_seq_yadder.sv
// yAdder: plain WIDTH-bit ripple-carry adder, the only adder in the multiplier datapath.
module yAdder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] z,
  output logic             cout
);

  // Ripple the carry bit by bit through full-adder cells.
  always_comb begin
    logic c;
    c = cin;
    z = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      z[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/add_shift_mul_seq.sv
// add_shift_mul_seq: unsigned WIDTH x WIDTH -> 2*WIDTH multiplier, one shift-and-add
// iteration per clock through a single shared yAdder.
// Optional feature: define ADDSEQ_EARLY_TERM_EN to finish as soon as the remaining
// multiplier bits are all zero.
module add_shift_mul_seq
  import add_shift_mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  add_shift_mul_seq_if.slave bus
);

  localparam int unsigned CNT_W = cnt_w(WIDTH);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     add_a, add_b, add_z;
  logic                 add_cout;
  logic [WIDTH-1:0]     step_hi, step_lo;
  logic                 early_done;
  logic [2*WIDTH-1:0]   early_prod;

  // Adder ports are held at zero outside RUN.
  assign add_a = (state_q == S_RUN) ? acc_hi_q : '0;
  assign add_b = (state_q == S_RUN && acc_lo_q[0]) ? mcand_q : '0;

  yAdder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (1'b0),
    .z    (add_z),
    .cout (add_cout)
  );

  // {cout, z, acc_lo} >> 1 keeps the carry as the new top product bit.
  assign step_hi = {add_cout, add_z[WIDTH-1:1]};
  assign step_lo = {add_z[0], acc_lo_q[WIDTH-1:1]};

`ifdef ADDSEQ_EARLY_TERM_EN
  logic [WIDTH-1:0] pend_mask;
  // Low WIDTH-count bits of acc_lo are multiplier bits not yet consumed.
  assign pend_mask  = {WIDTH{1'b1}} >> count_q;
  assign early_done = ((acc_lo_q & pend_mask) == '0);
  assign early_prod = {acc_hi_q, acc_lo_q} >> (CNT_W'(WIDTH) - count_q);
`else
  assign early_done = 1'b0;
  assign early_prod = '0;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    mcand_d   = mcand_q;
    count_d   = count_q;
    product_d = product_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d  = S_RUN;
          mcand_d  = bus.a;
          acc_lo_d = bus.b;
          acc_hi_d = '0;
          count_d  = '0;
        end
      end
      S_RUN: begin
        if (early_done) begin
          state_d   = S_DONE;
          product_d = early_prod;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          count_d  = count_q + CNT_W'(1);
          if (count_q == CNT_W'(WIDTH - 1)) begin
            state_d   = S_DONE;
            product_d = {step_hi, step_lo};
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      mcand_q   <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      mcand_q   <= mcand_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_RUN);
  assign bus.product   = product_q;

endmodule

// File: tb/tb_add_shift_mul_seq.sv
// Self-checking bench for add_shift_mul_seq (WIDTH=32), randomized against a plain
// arithmetic reference. Expected latency follows ADDSEQ_EARLY_TERM_EN when defined.
module tb_add_shift_mul_seq;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  add_shift_mul_seq_if #(.WIDTH(W)) bus ();

  add_shift_mul_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (got hang, required finish)");
    $fatal(1);
  end

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    return 64'(x) * 64'(y);
  endfunction

  // Edges after the accepting edge until out_valid is seen.
  function automatic int exp_lat(input logic [31:0] y);
    int k;
    int early;
    k = -1;
    for (int i = 0; i < W; i++) if (y[i]) k = i;
    early = (k < 0) ? 1 : ((k + 2 > W) ? W : k + 2);
`ifdef ADDSEQ_EARLY_TERM_EN
    return early;
`else
    return (early > 0) ? W : W;
`endif
  endfunction

  task automatic start_op(input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    bus.a        = x;
    bus.b        = y;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit timed_out);
    lat       = 0;
    timed_out = 1'b1;
    for (int i = 0; i < W + 8; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.out_valid) begin
        timed_out = 1'b0;
        i = W + 8;
      end
    end
  endtask

  task automatic finish_op();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got in_ready=%b out_valid=%b busy=%b, required 1 0 0",
               bus.in_ready, bus.out_valid, bus.busy);
    end
    n_tests++;
    if (bus.product !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_product: got %h, required 0", bus.product);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] xs[3];
    logic [31:0] ys[3];
    int          lat;
    bit          to;
    xs = '{32'd3, 32'hFFFF_FFFF, 32'h1234_5678};
    ys = '{32'd5, 32'hFFFF_FFFF, 32'd0};
    for (int t = 0; t < 3; t++) begin
      start_op(xs[t], ys[t]);
      n_tests++;
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL dir%0d_busy: got busy=%b in_ready=%b, required 1 0", t, bus.busy,
                 bus.in_ready);
      end
      wait_done(lat, to);
      n_tests++;
      if (to || lat != exp_lat(ys[t])) begin
        n_fail++;
        $display("FAIL dir%0d_latency: got %0d (timeout=%0d), required %0d", t, lat, to,
                 exp_lat(ys[t]));
      end
      n_tests++;
      if (bus.product !== ref_mul(xs[t], ys[t])) begin
        n_fail++;
        $display("FAIL dir%0d_product: got %h, required %h", t, bus.product,
                 ref_mul(xs[t], ys[t]));
      end
      finish_op();
      n_tests++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL dir%0d_release: got in_ready=%b out_valid=%b, required 1 0", t,
                 bus.in_ready, bus.out_valid);
      end
    end
  endtask

  task automatic test_hold();
    logic [63:0] exp;
    int          lat;
    bit          to;
    int          bad;
    exp = ref_mul(32'd1000, 32'd77);
    start_op(32'd1000, 32'd77);
    wait_done(lat, to);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = (i % 2 == 0);
      bus.a        = $urandom;
      bus.b        = $urandom;
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b1 || bus.product !== exp || bus.in_ready !== 1'b0 ||
          bus.busy !== 1'b0) bad++;
    end
    n_tests++;
    if (to || bad != 0) begin
      n_fail++;
      $display("FAIL hold_stable: got %0d unstable cycles (timeout=%0d), required 0", bad, to);
    end
    bus.in_valid = 1'b0;
    finish_op();
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: got in_ready=%b out_valid=%b, required 1 0",
               bus.in_ready, bus.out_valid);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_ignored_in: got busy=%b in_ready=%b, required 0 1", bus.busy,
               bus.in_ready);
    end
  endtask

  task automatic test_reset_midrun();
    int lat;
    bit to;
    start_op(32'd9, 32'hF000_000F);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.product !== 64'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: got in_ready=%b out_valid=%b busy=%b product=%h, required 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.product);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_op(32'd7, 32'd6);
    wait_done(lat, to);
    n_tests++;
    if (to || lat != exp_lat(32'd6) || bus.product !== 64'd42) begin
      n_fail++;
      $display("FAIL after_reset_op: got product=%h lat=%0d timeout=%0d, required 42 lat=%0d",
               bus.product, lat, to, exp_lat(32'd6));
    end
    finish_op();
  endtask

  task automatic test_back_to_back();
    logic [31:0] x;
    logic [31:0] y;
    int          lat;
    bit          to;
    int          stall;
    for (int n = 0; n < 100; n++) begin
      x = $urandom;
      y = $urandom >> $urandom_range(0, 31);
      if (n % 25 == 3) y = 32'd0;
      if (n % 25 == 7) begin
        x = 32'hFFFF_FFFF;
        y = 32'hFFFF_FFFF;
      end
      start_op(x, y);
      wait_done(lat, to);
      stall = $urandom_range(0, 3);
      repeat (stall) @(posedge clk);
      #1;
      n_tests++;
      if (to || lat != exp_lat(y)) begin
        n_fail++;
        $display("FAIL b2b%0d_latency: got %0d (timeout=%0d), required %0d", n, lat, to,
                 exp_lat(y));
      end
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.product !== ref_mul(x, y)) begin
        n_fail++;
        $display("FAIL b2b%0d_product: got %h (out_valid=%b) for %h*%h, required %h", n,
                 bus.product, bus.out_valid, x, y, ref_mul(x, y));
      end
      finish_op();
    end
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_hold();
    test_reset_midrun();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
